// File: rtl/sr04_uart_report_if.sv
// Connection between the SR04 ranging stage and the UART distance reporter:
// the sample strobe and value going in, the serial line and status coming out.
interface sr04_uart_report_if;
    logic [7:0] distance;
    logic       dist_valid;
    logic       tx;
    logic       busy;
    logic       overrun;

    modport master (
        output distance,
        output dist_valid,
        input  tx,
        input  busy,
        input  overrun
    );

    modport slave (
        input  distance,
        input  dist_valid,
        output tx,
        output busy,
        output overrun
    );
endinterface

// File: rtl/sr04_uart_report.sv
// Reports each accepted 8-bit distance sample as a 5-byte ASCII frame "DDD\r\n"
// on an 8N1 UART line, using a sequential double-dabble binary-to-BCD converter.
module sr04_uart_report #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic              clk,
    input  logic              rst_n,
    sr04_uart_report_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, LOAD, SHIFT} state_t;

    state_t          state_reg;
    logic [7:0]      bin_reg;
    logic [11:0]     bcd_reg;
    logic [2:0]      conv_cnt_reg;
    logic [BW-1:0]   baud_cnt_reg;
    logic [3:0]      bit_cnt_reg;
    logic [2:0]      byte_idx_reg;
    logic [8:0]      shift_reg;
    logic            tx_reg;
    logic            busy_reg;
    logic            overrun_reg;

    logic [11:0]     bcd_adj;
    logic [19:0]     dabble_next;
    logic [2:0]      sel_idx;
    logic [7:0]      sel_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_nibble_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        dabble_next = {bcd_adj, bin_reg} << 1;
    end

    // During the stop bit the mux already points at the next byte, so the
    // following start bit can be launched on the very edge the stop bit ends.
    always_comb begin
        sel_idx  = (state_reg == LOAD) ? byte_idx_reg : byte_idx_reg + 3'd1;
        sel_byte = 8'h0A;
        case (sel_idx)
            3'd0:    sel_byte = {4'h3, bcd_reg[11:8]};
            3'd1:    sel_byte = {4'h3, bcd_reg[7:4]};
            3'd2:    sel_byte = {4'h3, bcd_reg[3:0]};
            3'd3:    sel_byte = 8'h0D;
            default: sel_byte = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            conv_cnt_reg <= '0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= bus.dist_valid && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (bus.dist_valid) begin
                        bin_reg      <= bus.distance;
                        bcd_reg      <= '0;
                        conv_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    bcd_reg      <= dabble_next[19:8];
                    bin_reg      <= dabble_next[7:0];
                    conv_cnt_reg <= conv_cnt_reg + 3'd1;
                    if (conv_cnt_reg == 3'd7) state_reg <= LOAD;
                end
                LOAD: begin
                    tx_reg       <= 1'b0;
                    shift_reg    <= {1'b1, sel_byte};
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    state_reg    <= SHIFT;
                end
                SHIFT: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 4'd9) begin
                            if (byte_idx_reg == 3'd4) begin
                                byte_idx_reg <= '0;
                                busy_reg     <= 1'b0;
                                tx_reg       <= 1'b1;
                                state_reg    <= IDLE;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 3'd1;
                                bit_cnt_reg  <= '0;
                                tx_reg       <= 1'b0;
                                shift_reg    <= {1'b1, sel_byte};
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b1, shift_reg[8:1]};
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.tx      = tx_reg;
    assign bus.busy    = busy_reg;
    assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_sr04_uart_report.sv
// Directed bench for sr04_uart_report: decodes each UART frame bit by bit at a
// reduced bit period and compares against hand-computed ASCII frames.
module tb_sr04_uart_report;
    localparam int CLK_FREQ = 1_050_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = 10;   // 1_050_000 / 100_000, truncated

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sr04_uart_report_if bus ();

    sr04_uart_report #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sends one sample and walks the whole frame cycle by cycle from edge N.
    task automatic run_frame(input logic [7:0] d, input logic [23:0] exp_digits, input bit with_drop);
        int total;
        int rel;
        int byt;
        int bitn;
        int pos;
        logic first;
        logic [7:0] rx;
        logic [7:0] exp_b;
        logic [39:0] got;
        total = 9 + 50 * DIV;
        first = 1'b0;
        rx    = '0;
        got   = '0;
        @(negedge clk);
        bus.distance   = d;
        bus.dist_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.dist_valid = 1'b0;
        check("busy_on_accept", bus.busy, 1);
        check("no_overrun_on_accept", bus.overrun, 0);
        for (int c = 1; c <= total; c++) begin
            if (with_drop && c == 120) begin
                bus.distance   = 8'd50;
                bus.dist_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (with_drop && c == 120) begin
                bus.dist_valid = 1'b0;
                bus.distance   = d;
                check("overrun_pulse", bus.overrun, 1);
            end
            if (with_drop && c == 121) check("overrun_one_cycle", bus.overrun, 0);
            if (c == 8) check("tx_high_before_start", bus.tx, 1);
            if (c == total - 1) check("busy_before_end", bus.busy, 1);
            if (c == total) begin
                check("busy_falls", bus.busy, 0);
                check("tx_idle_after_frame", bus.tx, 1);
            end
            if (c >= 9 && c < total) begin
                rel  = c - 9;
                byt  = rel / (10 * DIV);
                bitn = (rel % (10 * DIV)) / DIV;
                pos  = rel % DIV;
                if (pos == 0) first = bus.tx;
                if (pos == DIV - 1) begin
                    check("bit_width", bus.tx, first);
                    if (bitn == 0) check("start_bit", bus.tx, 0);
                    else if (bitn <= 8) rx[bitn-1] = bus.tx;
                    else begin
                        check("stop_bit", bus.tx, 1);
                        case (byt)
                            0:       exp_b = exp_digits[23:16];
                            1:       exp_b = exp_digits[15:8];
                            2:       exp_b = exp_digits[7:0];
                            3:       exp_b = 8'h0D;
                            default: exp_b = 8'h0A;
                        endcase
                        check("frame_byte", rx, exp_b);
                        got[39-8*byt -: 8] = rx;
                    end
                end
            end
        end
        $display("frame distance=%0d bytes=%010h", d, got);
    endtask

    initial begin
        bit tx_low_seen;
        bit busy_seen;
        bit ovr_seen;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.distance   = '0;
        bus.dist_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", bus.tx, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_overrun", bus.overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;

        tx_low_seen = 0; busy_seen = 0; ovr_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (!bus.tx) tx_low_seen = 1;
            if (bus.busy) busy_seen = 1;
            if (bus.overrun) ovr_seen = 1;
        end
        check("idle_tx_high", tx_low_seen, 0);
        check("idle_busy_low", busy_seen, 0);
        check("idle_overrun_low", ovr_seen, 0);
        $display("idle 1000 cycles done");

        run_frame(8'd123, "123", 1'b1);
        tx_low_seen = 0; busy_seen = 0;
        for (int i = 0; i < 30 * DIV; i++) begin
            @(posedge clk);
            #1;
            if (!bus.tx) tx_low_seen = 1;
            if (bus.busy) busy_seen = 1;
        end
        check("dropped_no_frame_tx", tx_low_seen, 0);
        check("dropped_no_frame_busy", busy_seen, 0);

        // Back-to-back: each call accepts on the first cycle busy reads 0.
        run_frame(8'd0,   "000", 1'b0);
        run_frame(8'd255, "255", 1'b0);
        run_frame(8'd9,   "009", 1'b0);
        run_frame(8'd100, "100", 1'b0);

        @(negedge clk);
        bus.distance   = 8'd200;
        bus.dist_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.dist_valid = 1'b0;
        repeat (9 + 13 * DIV + DIV / 2 - 1) @(posedge clk);
        #1;
        check("tx_low_in_byte1_bit3", bus.tx, 0);
        check("busy_mid_frame", bus.busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", bus.tx, 1);
        check("async_reset_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-frame applied and released");
        tx_low_seen = 0; busy_seen = 0;
        for (int i = 0; i < 20 * DIV; i++) begin
            @(posedge clk);
            #1;
            if (!bus.tx) tx_low_seen = 1;
            if (bus.busy) busy_seen = 1;
        end
        check("no_resume_tx", tx_low_seen, 0);
        check("no_resume_busy", busy_seen, 0);
        run_frame(8'd42, "042", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr04_uart_report.md
Name: sr04_uart_report

Overview:
- Downstream consumer of the SR04 ranging stage. Takes each new 8-bit distance sample (cm) and reports it over a UART TX line.
- Each sample is sent as a fixed 5-byte ASCII frame: three decimal digits, then CR, then LF.
- Converts binary to BCD sequentially (shift-add-3), then serialises 8N1, LSB first.
- Gives a human-readable distance stream on a PC terminal with no CPU involved.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. Bit period DIV = CLK_FREQ/BAUD (integer truncation; 434 at defaults).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- distance  input  8  distance in cm from the ranging stage; sampled only on an accepted dist_valid
- dist_valid  input  1  single-cycle strobe; the ranging stage raises it once per completed echo
- tx  output  1  UART serial out; idle high
- busy  output  1  high from acceptance until the last stop bit of the frame ends
- overrun  output  1  one-cycle pulse when dist_valid arrives while busy

Behaviour:
- Reset: tx=1, busy=0, overrun=0, state=IDLE, all counters 0. Asynchronous assert; release is synchronous to clk.
- Reset mid-frame: tx returns high immediately and the partial frame is abandoned. The next frame starts only on a new dist_valid.
- Registered outputs only; no combinational path from inputs to tx or busy.
- Acceptance: at clock edge N, if state=IDLE and dist_valid=1:
  - latch distance;
  - set busy=1 on edge N;
  - go to CONV.
- Drop: dist_valid=1 while not IDLE sets overrun=1 for exactly one cycle. The sample is discarded and the current frame is unaffected.
- CONV:
  - 8 iterations of double dabble on a 12-bit BCD shadow, one per clock;
  - on each iteration, add 3 to any nibble >=5 before shifting.
  - Result: hundreds 0..2, tens 0..9, ones 0..9.
- Frame bytes, in order:
  - 0x30+hundreds, 0x30+tens, 0x30+ones, 0x0D, 0x0A;
  - leading zeros are always sent (distance 7 -> "007").
- Timing:
  - start bit of byte 0 (tx=0) begins on edge N+9;
  - each bit lasts exactly DIV clocks;
  - bit order: start(0), d0..d7, stop(1).
- Byte-to-byte: the next start bit begins on the clock immediately after the previous stop bit's DIV clocks. No idle gap.
- Frame length: 50*DIV clocks from start of byte 0 to end of byte 4 stop bit (21700 at defaults).
- Completion:
  - busy falls on the edge that ends the last stop bit; state returns to IDLE on the same edge;
  - tx stays 1.
  - A dist_valid on the first cycle busy reads 0 is accepted.
- States: IDLE -> CONV (8 clk) -> LOAD (select byte, 1 clk) -> SHIFT (10 bits x DIV) -> LOAD while byte index <4; otherwise -> IDLE.
  - Byte index wraps to 0 on return to IDLE.
  - The LOAD cycle is counted inside the 9-cycle latency and does not add inter-byte gaps: the byte mux is pre-selected during the stop bit.
- Counters:
  - baud counter sized for ceil(log2(DIV));
  - bit counter 0..9;
  - byte index 0..4;
  - conversion counter 0..7.

Test Plan:
- Reset then idle 1000 clk -> tx=1, busy=0, overrun=0 throughout.
- distance=123, dist_valid pulse at edge N -> busy=1 at N; tx falls at N+9; decoded bytes 0x31 0x32 0x33 0x0D 0x0A; each bit 434±0 clk; busy falls at N+9+21700.
- distance=0 and distance=255 (separate frames) -> "000\r\n" and "255\r\n". Also 9 -> "009", 100 -> "100".
- Second dist_valid (distance=50) mid-frame of 123 -> overrun high exactly 1 clk; frame still "123\r\n"; no frame for 50.
- rst_n low at bit 3 of byte 1 -> tx=1 and busy=0 within the reset assertion (asynchronous). After release, dist_valid with 42 -> clean "042\r\n".
- dist_valid on the first cycle after busy falls -> accepted, no overrun, new frame starts 9 clk later.
